// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_pkg
// Description : Shared types, constants and the LFSR step function for the
//               shared random-source arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } rng_state_t;

    // Value the LFSR jumps to when stepped from the all-zero lock-up state
    localparam logic [7:0] LFSR_ZERO_FILL = 8'h66;
    // LFSR contents after reset
    localparam logic [7:0] LFSR_RESET     = 8'h66;
    // Default feedback tap mask
    localparam logic [7:0] DEFAULT_TAPS   = 8'hB8;

    // One Fibonacci step: shift right, feedback into the MSB; escape all-zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] taps);
        if (cur == 8'h00) begin
            return LFSR_ZERO_FILL;
        end
        return {^(taps & cur), cur[7:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8_core
// Description : 8-bit Fibonacci LFSR with synchronous load, single-step
//               enable and all-zero escape.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8_core
    import rng_pkg::*;
#(
    parameter logic [7:0] TAPS = DEFAULT_TAPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] r_state;

    // LFSR register: reset, then load, then step, in that priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= LFSR_RESET;
        end else if (load) begin
            r_state <= load_val;
        end else if (step) begin
            r_state <= lfsr_next(r_state, TAPS);
        end
    end

    assign q = r_state;

endmodule
`default_nettype wire

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rng_arbiter
// Description : Round-robin sharing of one 8-bit LFSR among NREQ requesters.
//               Each draw advances the LFSR STEPS times, then delivers the
//               byte with a one-cycle grant pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int         NREQ  = 4,
    parameter logic [7:0] TAPS  = DEFAULT_TAPS,
    parameter int         STEPS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      seed_load,
    input  logic [7:0]                seed,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic [7:0]                rdata,
    output logic                      rvalid,
    output logic                      busy,
    output logic [7:0]                lfsr_q
);

    localparam int              c_IDW        = $clog2(NREQ);
    localparam logic [7:0]      c_STEP_LAST  = 8'(STEPS - 1);
    localparam logic [c_IDW-1:0] c_LAST_RESET = c_IDW'(NREQ - 1);

    rng_state_t       r_state;
    rng_state_t       w_state_next;
    logic [7:0]       r_step_cnt;
    logic [c_IDW-1:0] r_winner;
    logic [c_IDW-1:0] r_last;
    logic [c_IDW-1:0] r_gnt_id;
    logic [7:0]       r_rdata;
    logic [c_IDW-1:0] w_pick;
    logic             w_pick_valid;
    logic             w_step;
    logic [7:0]       w_lfsr_q;

    lfsr8_core #(
        .TAPS (TAPS)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed),
        .step     (w_step),
        .q        (w_lfsr_q)
    );

    // Round-robin search: nearest active request above the last winner, with wrap
    always_comb begin
        int               idx;
        logic [c_IDW-1:0] idx_n;
        idx          = 0;
        idx_n        = '0;
        w_pick       = r_last;
        w_pick_valid = 1'b0;
        // Scan farthest-first so the closest candidate is the one that sticks
        for (int k = NREQ; k >= 1; k--) begin
            idx   = (int'(r_last) + k) % NREQ;
            idx_n = c_IDW'(idx);
            if (req[idx_n]) begin
                w_pick       = idx_n;
                w_pick_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; seed_load forces a return to IDLE
    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        busy         = 1'b0;
        rvalid       = 1'b0;
        gnt          = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                busy   = 1'b1;
                if (r_step_cnt == c_STEP_LAST) begin
                    w_state_next = DELIVER;
                end
            end
            DELIVER: begin
                busy          = 1'b1;
                rvalid        = 1'b1;
                gnt[r_winner] = 1'b1;
                w_state_next  = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (seed_load) begin
            w_state_next = IDLE;
        end
    end

    // Draw bookkeeping: winner latch, step count, delivered byte, RR pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step_cnt <= 8'd0;
            r_winner   <= '0;
            r_last     <= c_LAST_RESET;
            r_gnt_id   <= '0;
            r_rdata    <= 8'd0;
        end else if (!seed_load) begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_winner   <= w_pick;
                        r_step_cnt <= 8'd0;
                    end
                end
                SHIFT: begin
                    r_step_cnt <= r_step_cnt + 8'd1;
                    // Capture the post-final-step value so rdata is valid alongside gnt
                    if (r_step_cnt == c_STEP_LAST) begin
                        r_rdata <= lfsr_next(w_lfsr_q, TAPS);
                    end
                end
                DELIVER: begin
                    r_last   <= r_winner;
                    r_gnt_id <= r_winner;
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt_id = r_gnt_id;
    assign rdata  = r_rdata;
    assign lfsr_q = w_lfsr_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_arbiter
// Description : Self-checking bench for rng_arbiter (NREQ=4, STEPS=3) using a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_arbiter;

    localparam int         NREQ  = 4;
    localparam int         STEPS = 3;
    localparam logic [7:0] TAPS  = 8'hB8;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            seed_load = 1'b0;
    logic [7:0]      seed      = 8'h00;
    logic [NREQ-1:0] req       = '0;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_id;
    logic [7:0]      rdata;
    logic            rvalid;
    logic            busy;
    logic [7:0]      lfsr_q;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] m_lfsr  = 8'h66;
    int         m_last  = NREQ - 1;
    logic [7:0] m_rdata = 8'h00;
    int         m_gntid = 0;

    rng_arbiter #(
        .NREQ  (NREQ),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] step1(input logic [7:0] r);
        if (r == 8'h00) return 8'h66;
        return {^(r & TAPS), r[7:1]};
    endfunction

    // Winner = first active requester scanning upward from last+1 with wrap
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after DELIVER
    task automatic do_draw(input logic [NREQ-1:0] r, input logic [NREQ-1:0] r_after, input string tag);
        int         w;
        logic [7:0] exp;
        logic [NREQ-1:0] exp_gnt;
        w   = pick(r, m_last);
        exp = m_lfsr;
        repeat (STEPS) exp = step1(exp);
        exp_gnt = '0;
        exp_gnt[w[1:0]] = 1'b1;
        req = r;
        @(negedge clk);
        req = r_after;
        chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
        for (int i = 0; i < STEPS; i++) begin
            chk({tag, "_gnt_early"}, 32'(gnt), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_gnt"},    32'(gnt),    32'(exp_gnt));
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"},  32'(rdata),  32'(exp));
        m_lfsr  = exp;
        m_rdata = exp;
        m_last  = w;
        m_gntid = w;
        @(negedge clk);
        chk({tag, "_gnt_off"}, 32'(gnt),    32'd0);
        chk({tag, "_gnt_id"},  32'(gnt_id), 32'(m_gntid));
        chk({tag, "_idle"},    32'(busy),   32'd0);
    endtask

    task automatic do_seed(input logic [7:0] s, input string tag);
        req       = '0;
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = s;
        chk({tag, "_lfsr"}, 32'(lfsr_q), 32'(s));
        chk({tag, "_busy"}, 32'(busy),   32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_gnt",    32'(gnt),    32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_rdata",  32'(rdata),  32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_lfsr",   32'(lfsr_q), 32'h66);

        // All requesters held: strict rotation, back-to-back STEPS+2 spacing
        reset = 1'b1;
        do_draw(4'b1111, 4'b1111, "rr0");
        do_draw(4'b1111, 4'b1111, "rr1");
        do_draw(4'b1111, 4'b1111, "rr2");
        do_draw(4'b1111, 4'b1111, "rr3");
        do_draw(4'b1111, 4'b0000, "rr4");
        chk("rr_last_id", 32'(gnt_id), 32'd0);

        // Known seed, single requester
        do_seed(8'h80, "seed80");
        do_draw(4'b0001, 4'b0000, "s80");

        // Zero-fill path: 02 -> 01 -> 00 -> 66
        do_seed(8'h02, "seed02");
        do_draw(4'b0010, 4'b0000, "zfill");
        chk("zfill_rdata_const", 32'(rdata),  32'h66);
        chk("zfill_gnt_id",      32'(gnt_id), 32'd1);

        // Round robin skip, requester 2 drops mid-SHIFT but is still served
        do_draw(4'b0001, 4'b0000, "p0");
        do_draw(4'b0101, 4'b0001, "p2drop");
        do_draw(4'b0001, 4'b0000, "p0b");

        // seed_load in the third SHIFT cycle aborts the draw
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 8'h5A;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = 8'h5A;
        chk("abort_gnt",    32'(gnt),    32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_lfsr",   32'(lfsr_q), 32'h5A);
        chk("abort_rdata",  32'(rdata),  32'(m_rdata));
        chk("abort_gnt_id", 32'(gnt_id), 32'(m_gntid));
        repeat (STEPS + 2) begin
            @(negedge clk);
            chk("abort_quiet", 32'(gnt), 32'd0);
        end
        do_draw(4'b0110, 4'b0000, "post_abort");

        // Reset with seed_load during SHIFT
        req = 4'b1111;
        @(negedge clk);
        reset     = 1'b0;
        seed_load = 1'b1;
        seed      = 8'h3C;
        @(negedge clk);
        chk("rst2_gnt",    32'(gnt),    32'd0);
        chk("rst2_rvalid", 32'(rvalid), 32'd0);
        chk("rst2_busy",   32'(busy),   32'd0);
        chk("rst2_rdata",  32'(rdata),  32'd0);
        chk("rst2_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst2_lfsr",   32'(lfsr_q), 32'h66);
        reset     = 1'b1;
        seed_load = 1'b0;
        m_lfsr    = 8'h66;
        m_last    = NREQ - 1;
        m_rdata   = 8'h00;
        m_gntid   = 0;
        do_draw(4'b0110, 4'b0000, "rst2_first");

        // Randomized draws with occasional reseeding
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_seed(8'($urandom), "rseed");
            end
            do_draw(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), "rand");
        end

        req = '0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
